layer_serializer: RTL and testbench

LAYER_SERIALIZER -- requirements
Module: layer_serializer

---
 rtl/layer_serializer.sv | 108 ++++++++++
 tb/tb_layer_serializer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/layer_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : layer_serializer
//  Purpose  : Captures an NN-wide vector of neuron outputs in one cycle and
//             streams it out one element per handshake (valid/ready), with
//             back-to-back vector chaining and a sticky overrun flag.
//  Revision : 1.0 - initial release
// ============================================================================
module layer_serializer #(
    parameter int NN        = 30,
    parameter int dataWidth = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NN-1:0]           in_valid,
    input  logic [NN*dataWidth-1:0] in_data,
    output logic                    out_valid,
    output logic [dataWidth-1:0]    out_data,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic                    busy,
    output logic                    overrun
);

    localparam int              c_CW   = (NN > 1) ? $clog2(NN) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(NN - 1);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_SEND = 1'b1;

    logic [0:0]              r_state;
    logic [c_CW-1:0]         r_cnt;
    logic [NN*dataWidth-1:0] r_buf;
    logic                    r_overrun;

    logic                    w_capture;
    logic                    w_hs;
    logic                    w_final;
    logic                    w_send;
    logic [dataWidth-1:0]    w_out_data;
    logic                    w_unused_valid;

    // All neurons of a layer finish together, so bit 0 alone triggers capture;
    // the remaining valid bits are deliberately ignored.
    assign w_capture      = in_valid[0];
    assign w_unused_valid = ^in_valid;

    assign w_send  = (r_state == c_SEND);
    assign w_hs    = w_send && out_ready;
    assign w_final = w_hs && (r_cnt == c_LAST);

    // Element select: loop compare avoids a zero-width index when NN is 1.
    always_comb begin
        w_out_data = '0;
        for (int i = 0; i < NN; i++) begin
            if (r_cnt == c_CW'(i)) begin
                w_out_data = r_buf[i*dataWidth +: dataWidth];
            end
        end
    end

    assign out_valid = w_send;
    assign busy      = w_send;
    assign out_last  = w_send && (r_cnt == c_LAST);
    assign out_data  = w_out_data;
    assign overrun   = r_overrun;

    // Capture / stream state machine with element index and sticky overrun.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= c_IDLE;
            r_cnt     <= '0;
            r_buf     <= '0;
            r_overrun <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_capture) begin
                        r_buf   <= in_data;
                        r_cnt   <= '0;
                        r_state <= c_SEND;
                    end
                end
                c_SEND: begin
                    if (w_hs && (r_cnt != c_LAST)) begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                    if (w_final) begin
                        // Last element leaves this cycle: chain a new vector
                        // with no bubble, or fall back to idle.
                        if (w_capture) begin
                            r_buf <= in_data;
                            r_cnt <= '0;
                        end else begin
                            r_state <= c_IDLE;
                        end
                    end else if (w_capture) begin
                        // No room for the incoming vector: drop it.
                        r_overrun <= 1'b1;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_layer_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_layer_serializer
//  Purpose  : Scoreboard bench for layer_serializer (NN=3, dataWidth=16).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_layer_serializer;

    localparam int NN = 3;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NN-1:0]     in_valid = '0;
    logic [NN*DW-1:0]  in_data = '0;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic              out_ready = 1'b1;
    logic              out_last;
    logic              busy;
    logic              overrun;

    layer_serializer #(.NN(NN), .dataWidth(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .out_last (out_last),
        .busy     (busy),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int valid_cycles = 0;

    logic [DW:0]   exp_q[$];   // {last, data}
    logic [DW:0]   mon_e;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    localparam logic [NN*DW-1:0] V1 = {16'h0003, 16'h0002, 16'h0001};
    localparam logic [NN*DW-1:0] V2 = {16'h0006, 16'h0005, 16'h0004};
    localparam logic [NN*DW-1:0] V3 = {16'h0009, 16'h0008, 16'h0007};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_vec(input logic [NN*DW-1:0] v);
        for (int i = 0; i < NN; i++) begin
            exp_q.push_back({(i == NN - 1), v[i*DW +: DW]});
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(name, exp_q.size(), 0);
        step();
    endtask

    // Monitor: pops the scoreboard on each handshake and checks stall stability.
    always @(negedge clk) begin
        if (rst) begin
            if (out_valid) valid_cycles++;
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, prev_data);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_elem: got %0h expected none", out_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("elem_data", out_data, mon_e[DW-1:0]);
                    chk("elem_last", out_last, mon_e[DW]);
                end
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_last", out_last, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_data", out_data, 0);
        rst = 1'b1;
        step();

        // Basic stream
        valid_cycles = 0;
        in_valid = 3'b001; in_data = V1; push_vec(V1);
        step();
        in_valid = '0;
        chk("latency_valid", out_valid, 1);
        chk("latency_data", out_data, 16'h0001);
        drain("basic_drain");
        chk("basic_cycles", valid_cycles, 3);

        // Backpressure on element 1 for two cycles
        valid_cycles = 0;
        in_valid = 3'b001; in_data = V1; push_vec(V1);
        step();
        in_valid = '0;
        step();
        out_ready = 1'b0;
        step();
        step();
        chk("bp_held_data", out_data, 16'h0002);
        out_ready = 1'b1;
        drain("bp_drain");
        chk("bp_cycles", valid_cycles, 5);

        // Back-to-back vectors
        valid_cycles = 0;
        in_valid = 3'b001; in_data = V1; push_vec(V1);
        step();
        in_valid = '0;
        step();
        step();
        in_valid = 3'b001; in_data = V2; push_vec(V2);
        step();
        in_valid = '0;
        chk("b2b_valid", out_valid, 1);
        chk("b2b_data", out_data, 16'h0004);
        drain("b2b_drain");
        chk("b2b_cycles", valid_cycles, 6);
        chk("b2b_overrun", overrun, 0);

        // Partial valid is ignored
        in_valid = 3'b110; in_data = V2;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("partial_valid", out_valid, 0);
            chk("partial_busy", busy, 0);
        end
        in_valid = '0;

        // Overrun: capture while element 0 is on the output
        valid_cycles = 0;
        in_valid = 3'b001; in_data = V1; push_vec(V1);
        step();
        in_valid = 3'b001; in_data = V2;
        step();
        in_valid = '0;
        chk("ovr_set", overrun, 1);
        drain("ovr_drain");
        step();
        step();
        chk("ovr_sticky", overrun, 1);
        chk("ovr_cycles", valid_cycles, 3);

        // Reset mid-stream
        in_valid = 3'b001; in_data = V1; push_vec(V1);
        step();
        in_valid = '0;
        step();
        chk("mid_data_before", out_data, 16'h0002);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_last", out_last, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_overrun", overrun, 0);
        exp_q.delete();
        step();
        step();
        rst = 1'b1;
        step();
        chk("abort_valid", out_valid, 0);
        in_valid = 3'b001; in_data = V3; push_vec(V3);
        step();
        in_valid = '0;
        chk("post_rst_data", out_data, 16'h0007);
        drain("post_rst_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
